// File: rtl/acs_bank.sv
// ---------------------------------------------------------------------------
// acs_bank -- Viterbi add-compare-select bank with path-metric normalisation.
//
// One trellis step is taken on every cycle with in_valid=1 and start=0. For
// each state s, the two candidate metrics from predecessors p0=(2s) mod NSTATE
// and p1=p0+1 are added to their branch metrics, saturated, and the smaller
// one survives (ties keep p0). When every valid new metric has its MSB set,
// all valid metrics are shifted down by 2^(PMW-1) so they never overflow.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   start        re-initialise trellis: pm=0, only state 0 valid, step_cnt=0
//   in_valid     branch metrics present this cycle
//   bm0 / bm1    per-state branch metrics from p0 / p1, slice [s*BMW +: BMW]
//   out_valid    one-cycle pulse after an accepted step
//   decision     per-state survivor select (0 = p0, 1 = p1)
//   state_valid  per-state metric validity
//   best_state   lowest index among valid states with minimum metric
//   best_metric  metric of best_state
//   norm_event   normalisation applied on this out_valid
//   step_cnt     accepted steps since init, saturating
// ---------------------------------------------------------------------------
module acs_bank #(
    parameter int NSTATE = 4,
    parameter int BMW    = 2,
    parameter int PMW    = 8,
    parameter int CW     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [NSTATE*BMW-1:0]      bm0,
    input  logic [NSTATE*BMW-1:0]      bm1,
    output logic                       out_valid,
    output logic [NSTATE-1:0]          decision,
    output logic [NSTATE-1:0]          state_valid,
    output logic [$clog2(NSTATE)-1:0]  best_state,
    output logic [PMW-1:0]             best_metric,
    output logic                       norm_event,
    output logic [CW-1:0]              step_cnt
);

    localparam int             SW   = $clog2(NSTATE);
    localparam logic [PMW-1:0] HALF = PMW'(1) << (PMW - 1);

    logic [PMW-1:0]    pm [NSTATE];
    logic [NSTATE-1:0] pv;

    logic [PMW-1:0]    nxt_pm [NSTATE];
    logic [NSTATE-1:0] nxt_pv;
    logic [NSTATE-1:0] nxt_dec;
    logic              nxt_norm;
    logic [SW-1:0]     nxt_best;
    logic [PMW-1:0]    nxt_best_m;

    always_comb begin
        logic [SW-1:0]  p0;
        logic [SW-1:0]  p1;
        logic [PMW:0]   sum0;
        logic [PMW:0]   sum1;
        logic [PMW-1:0] c0;
        logic [PMW-1:0] c1;
        logic           all_msb;
        logic           found;

        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves a value held and no latch is inferred.
        p0         = '0;
        p1         = '0;
        sum0       = '0;
        sum1       = '0;
        c0         = '0;
        c1         = '0;
        all_msb    = 1'b1;
        found      = 1'b0;
        nxt_pv     = '0;
        nxt_dec    = '0;
        nxt_norm   = 1'b0;
        nxt_best   = '0;
        nxt_best_m = '0;
        for (int s = 0; s < NSTATE; s++) nxt_pm[s] = '0;

        // Add-compare-select per state.
        for (int s = 0; s < NSTATE; s++) begin
            // NSTATE is a power of two, so the mod is plain truncation.
            p0   = SW'(s << 1);
            p1   = p0 | SW'(1);
            sum0 = {1'b0, pm[p0]} + (PMW+1)'(bm0[s*BMW +: BMW]);
            sum1 = {1'b0, pm[p1]} + (PMW+1)'(bm1[s*BMW +: BMW]);
            c0   = sum0[PMW] ? '1 : sum0[PMW-1:0];
            c1   = sum1[PMW] ? '1 : sum1[PMW-1:0];
            nxt_pv[s] = pv[p0] | pv[p1];
            if (pv[p0] && pv[p1]) begin
                nxt_dec[s] = (c0 > c1);
                nxt_pm[s]  = (c0 > c1) ? c1 : c0;
            end else if (pv[p1]) begin
                nxt_dec[s] = 1'b1;
                nxt_pm[s]  = c1;
            end else if (pv[p0]) begin
                nxt_pm[s]  = c0;
            end
        end

        // Normalise only when all valid metrics sit in the upper half.
        for (int s = 0; s < NSTATE; s++)
            if (nxt_pv[s] && !nxt_pm[s][PMW-1]) all_msb = 1'b0;
        nxt_norm = (|nxt_pv) && all_msb;
        if (nxt_norm)
            for (int s = 0; s < NSTATE; s++)
                if (nxt_pv[s]) nxt_pm[s] = nxt_pm[s] - HALF;

        // Strict less-than keeps the lowest index on equal metrics.
        for (int s = 0; s < NSTATE; s++) begin
            if (nxt_pv[s] && (!found || nxt_pm[s] < nxt_best_m)) begin
                found      = 1'b1;
                nxt_best   = SW'(s);
                nxt_best_m = nxt_pm[s];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NSTATE; s++) pm[s] <= '0;
            pv          <= NSTATE'(1);
            step_cnt    <= '0;
            out_valid   <= 1'b0;
            decision    <= '0;
            state_valid <= '0;
            best_state  <= '0;
            best_metric <= '0;
            norm_event  <= 1'b0;
        end else if (start) begin
            // Concurrent in_valid is dropped; reported outputs are held.
            for (int s = 0; s < NSTATE; s++) pm[s] <= '0;
            pv         <= NSTATE'(1);
            step_cnt   <= '0;
            out_valid  <= 1'b0;
            norm_event <= 1'b0;
        end else if (in_valid) begin
            for (int s = 0; s < NSTATE; s++) pm[s] <= nxt_pm[s];
            pv          <= nxt_pv;
            decision    <= nxt_dec;
            state_valid <= nxt_pv;
            best_state  <= nxt_best;
            best_metric <= nxt_best_m;
            norm_event  <= nxt_norm;
            out_valid   <= 1'b1;
            if (step_cnt != {CW{1'b1}}) step_cnt <= step_cnt + CW'(1);
        end else begin
            out_valid  <= 1'b0;
            norm_event <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_bank.sv
// ---------------------------------------------------------------------------
// tb_acs_bank -- self-checking bench for acs_bank (NSTATE=4, BMW=2, PMW=8).
// A second instance with CW=4 shares the stimulus for counter saturation.
// The reference model keeps integer path metrics and applies the trellis
// rules with ordinary arithmetic after every clock edge.
// ---------------------------------------------------------------------------
module tb_acs_bank;

    localparam int N   = 4;
    localparam int BMW = 2;
    localparam int PMW = 8;
    localparam int VW  = 1 + 1 + N + N + 2 + PMW + 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           in_valid = 1'b0;
    logic [N*BMW-1:0] bm0 = '0;
    logic [N*BMW-1:0] bm1 = '0;

    logic           out_valid;
    logic [N-1:0]   decision;
    logic [N-1:0]   state_valid;
    logic [1:0]     best_state;
    logic [PMW-1:0] best_metric;
    logic           norm_event;
    logic [15:0]    step_cnt;

    logic           out_valid4;
    logic [N-1:0]   decision4;
    logic [N-1:0]   state_valid4;
    logic [1:0]     best_state4;
    logic [PMW-1:0] best_metric4;
    logic           norm_event4;
    logic [3:0]     step_cnt4;

    acs_bank #(.NSTATE(N), .BMW(BMW), .PMW(PMW), .CW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .bm0(bm0), .bm1(bm1), .out_valid(out_valid), .decision(decision),
        .state_valid(state_valid), .best_state(best_state),
        .best_metric(best_metric), .norm_event(norm_event), .step_cnt(step_cnt)
    );

    acs_bank #(.NSTATE(N), .BMW(BMW), .PMW(PMW), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .bm0(bm0), .bm1(bm1), .out_valid(out_valid4), .decision(decision4),
        .state_valid(state_valid4), .best_state(best_state4),
        .best_metric(best_metric4), .norm_event(norm_event4), .step_cnt(step_cnt4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state.
    int mpm [N];
    bit mpv [N];
    bit e_ov, e_norm;
    int e_dec, e_sv, e_best, e_bm, e_cnt;

    logic [VW-1:0] obs_vec;
    assign obs_vec = {out_valid, norm_event, decision, state_valid,
                      best_state, best_metric, step_cnt};

    function automatic logic [VW-1:0] exp_vec();
        return {e_ov, e_norm, N'(e_dec), N'(e_sv), 2'(e_best), 8'(e_bm), 16'(e_cnt)};
    endfunction

    function automatic int bm_of(input logic [N*BMW-1:0] v, input int s);
        return int'((v >> (s * BMW)) & 3);
    endfunction

    task automatic model_init();
        for (int s = 0; s < N; s++) begin
            mpm[s] = 0;
            mpv[s] = (s == 0);
        end
        e_cnt = 0;
        e_ov  = 0;
        e_norm = 0;
    endtask

    task automatic model_step(input logic [N*BMW-1:0] b0, input logic [N*BMW-1:0] b1);
        int npm [N];
        bit npv [N];
        int c0, c1, a, b, nval, nhigh, best_m;
        e_dec = 0;
        e_sv  = 0;
        for (int s = 0; s < N; s++) begin
            a  = (2 * s) % N;
            b  = a + 1;
            c0 = mpm[a] + bm_of(b0, s);
            c1 = mpm[b] + bm_of(b1, s);
            if (c0 > 255) c0 = 255;
            if (c1 > 255) c1 = 255;
            npv[s] = mpv[a] || mpv[b];
            npm[s] = 0;
            if (mpv[a] && mpv[b]) begin
                npm[s] = (c1 < c0) ? c1 : c0;
                if (c1 < c0) e_dec += (1 << s);
            end else if (mpv[b]) begin
                npm[s] = c1;
                e_dec += (1 << s);
            end else if (mpv[a]) begin
                npm[s] = c0;
            end
        end
        nval = 0;
        nhigh = 0;
        for (int s = 0; s < N; s++) if (npv[s]) begin
            nval++;
            if (npm[s] >= 128) nhigh++;
        end
        e_norm = (nval > 0) && (nhigh == nval);
        e_best = 0;
        best_m = 1 << 30;
        for (int s = 0; s < N; s++) begin
            if (e_norm && npv[s]) npm[s] -= 128;
            mpm[s] = npm[s];
            mpv[s] = npv[s];
            if (npv[s]) e_sv += (1 << s);
            if (npv[s] && npm[s] < best_m) begin
                best_m = npm[s];
                e_best = s;
            end
        end
        e_bm  = (nval > 0) ? best_m : 0;
        e_ov  = 1;
        e_cnt = (e_cnt < 65535) ? e_cnt + 1 : 65535;
    endtask

    // Apply one cycle of inputs, update the model at the edge, sample #1 later.
    task automatic drive(input bit r, input bit s, input bit v,
                         input logic [N*BMW-1:0] b0, input logic [N*BMW-1:0] b1);
        @(negedge clk);
        rst = r; start = s; in_valid = v; bm0 = b0; bm1 = b1;
        @(posedge clk);
        if (r) begin
            model_init();
            e_dec = 0; e_sv = 0; e_best = 0; e_bm = 0;
        end else if (s) begin
            model_init();
        end else if (v) begin
            model_step(b0, b1);
        end else begin
            e_ov = 0;
            e_norm = 0;
        end
        #1;
    endtask

    function automatic logic [N*BMW-1:0] rnd_bm();
        return (N*BMW)'($urandom);
    endfunction

    task automatic test_reset();
        drive(1, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        checks++;
        if (obs_vec !== '0) $display("FAIL reset_outputs: got %h want 0", obs_vec);
        else passes++;
    endtask

    task automatic test_first_step();
        drive(0, 0, 1, {N{2'd1}}, {N{2'd1}});
        checks++;
        if ({out_valid, state_valid, decision, best_state, best_metric, step_cnt} !==
            {1'b1, 4'b0101, 4'b0000, 2'd0, 8'd1, 16'd1})
            $display("FAIL first_step: got ov=%b sv=%b dec=%b bs=%0d bm=%0d cnt=%0d want 1/0101/0000/0/1/1",
                     out_valid, state_valid, decision, best_state, best_metric, step_cnt);
        else passes++;
        drive(0, 0, 0, '0, '0);
        checks++;
        if (obs_vec !== exp_vec()) $display("FAIL idle_hold: got %h want %h", obs_vec, exp_vec());
        else passes++;
    endtask

    task automatic test_tie_break();
        drive(1, 0, 0, '0, '0);
        drive(0, 0, 1, '0, '0);
        drive(0, 0, 1, '0, '0);
        drive(0, 0, 1, '0, '0);
        checks++;
        if (decision[1] !== 1'b0 || state_valid !== 4'b1111)
            $display("FAIL tie_break: got dec=%b sv=%b want dec[1]=0 sv=1111", decision, state_valid);
        else passes++;
        checks++;
        if (obs_vec !== exp_vec()) $display("FAIL tie_model: got %h want %h", obs_vec, exp_vec());
        else passes++;
    endtask

    task automatic test_normalisation();
        bit seen = 0;
        drive(1, 0, 0, '0, '0);
        for (int i = 0; i < 60 && !seen; i++) begin
            drive(0, 0, 1, {N{2'd3}}, {N{2'd3}});
            checks++;
            if (obs_vec !== exp_vec()) $display("FAIL norm_step%0d: got %h want %h", i, obs_vec, exp_vec());
            else passes++;
            if (e_norm) begin
                seen = 1;
                checks++;
                // 43 steps of 3 reach 129 in every valid state, then drop by 128.
                if (norm_event !== 1'b1 || best_metric !== 8'd1 || i != 42)
                    $display("FAIL norm_first: got ne=%b bm=%0d step=%0d want 1/1/42", norm_event, best_metric, i);
                else passes++;
            end
        end
        checks++;
        if (!seen) $display("FAIL norm_seen: got none want one within 60 steps");
        else passes++;
        drive(0, 0, 0, '0, '0);
        checks++;
        if (norm_event !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL norm_idle: got ne=%b ov=%b want 0/0", norm_event, out_valid);
        else passes++;
    endtask

    task automatic test_random();
        int errs = 0;
        drive(1, 0, 0, '0, '0);
        for (int i = 0; i < 300; i++) begin
            drive(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rnd_bm(), rnd_bm());
            checks++;
            if (obs_vec !== exp_vec()) begin
                if (errs < 5) $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec, exp_vec());
                errs++;
            end else passes++;
        end
    endtask

    task automatic test_start_with_valid();
        drive(0, 0, 1, rnd_bm(), rnd_bm());
        drive(0, 0, 1, rnd_bm(), rnd_bm());
        drive(0, 1, 1, rnd_bm(), rnd_bm());
        checks++;
        if (out_valid !== 1'b0 || step_cnt !== 16'd0 || obs_vec !== exp_vec())
            $display("FAIL start_drop: got ov=%b cnt=%0d vec=%h want ov=0 cnt=0 vec=%h",
                     out_valid, step_cnt, obs_vec, exp_vec());
        else passes++;
        drive(0, 0, 1, {N{2'd1}}, {N{2'd1}});
        checks++;
        if (state_valid !== 4'b0101 || step_cnt !== 16'd1 || out_valid !== 1'b1)
            $display("FAIL start_next: got sv=%b cnt=%0d ov=%b want 0101/1/1", state_valid, step_cnt, out_valid);
        else passes++;
    endtask

    task automatic test_midstream_reset();
        drive(0, 0, 1, rnd_bm(), rnd_bm());
        drive(0, 0, 1, rnd_bm(), rnd_bm());
        drive(1, 1, 1, rnd_bm(), rnd_bm());
        checks++;
        if (obs_vec !== '0) $display("FAIL midreset_outputs: got %h want 0", obs_vec);
        else passes++;
        drive(0, 0, 1, {N{2'd2}}, {N{2'd2}});
        checks++;
        if (obs_vec !== exp_vec() || state_valid !== 4'b0101)
            $display("FAIL midreset_resume: got %h want %h", obs_vec, exp_vec());
        else passes++;
    endtask

    task automatic test_counter_saturation();
        drive(1, 0, 0, '0, '0);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, rnd_bm(), rnd_bm());
        checks++;
        if (step_cnt4 !== 4'd15 || step_cnt !== 16'd20)
            $display("FAIL sat_count: got cnt4=%0d cnt16=%0d want 15/20", step_cnt4, step_cnt);
        else passes++;
        drive(0, 0, 0, '0, '0);
        drive(0, 0, 1, rnd_bm(), rnd_bm());
        checks++;
        if (step_cnt4 !== 4'd15 || out_valid4 !== 1'b1)
            $display("FAIL sat_hold: got cnt4=%0d ov4=%b want 15/1", step_cnt4, out_valid4);
        else passes++;
    endtask

    initial begin
        model_init();
        e_dec = 0; e_sv = 0; e_best = 0; e_bm = 0;
        test_reset();
        test_first_step();
        test_tie_break();
        test_normalisation();
        test_random();
        test_start_with_valid();
        test_midstream_reset();
        test_counter_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/acs_bank.md
ACS_BANK -- requirements
Module: acs_bank

Interface
REQ-001 SHALL have parameters, one per line:
- NSTATE, 4, trellis state count; power of two, >=2.
- BMW, 2, branch-metric width.
- PMW, 8, path-metric width; >= BMW+2.
- CW, 16, step-counter width.
REQ-002 SHALL have ports, one per line:
- clk, input, 1, sole clock; rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, re-initialise trellis.
- in_valid, input, 1, branch metrics present this cycle.
- bm0, input, NSTATE*BMW, branch metric into state s from predecessor p0; slice s = [s*BMW +: BMW].
- bm1, input, NSTATE*BMW, branch metric into state s from predecessor p1; same slicing.
- out_valid, output, 1, one-cycle pulse; step result registered.
- decision, output, NSTATE, per-state survivor select (0 = p0, 1 = p1).
- state_valid, output, NSTATE, per-state metric validity.
- best_state, output, log2(NSTATE), index of the minimum-metric valid state.
- best_metric, output, PMW, metric of best_state.
- norm_event, output, 1, normalisation applied on this out_valid.
- step_cnt, output, CW, accepted steps since init.

Function
REQ-003 SHALL hold internal pm[s] (PMW bits) and pv[s] (valid) for every state.
REQ-004 SHALL define predecessors of state s as p0 = (2s) mod NSTATE and p1 = p0+1.
REQ-005 SHALL accept a step on any cycle with in_valid=1 and start=0; there is no backpressure.
REQ-006 SHALL form cand0 = pm[p0]+bm0[s] and cand1 = pm[p1]+bm1[s] at PMW+1 bits, then saturate each to 2^PMW-1.
REQ-007 SHALL select per state:
- both predecessors invalid: sel=0, new pv=0, new pm=0.
- only p1 valid: sel=1.
- only p0 valid: sel=0.
- both valid: sel=1 iff cand0>cand1; ties give 0.
REQ-008 SHALL set new pv[s] = pv[p0] | pv[p1].
REQ-009 SHALL normalise: if at least one new metric is valid and every valid new metric has its MSB set, subtract 2^(PMW-1) from all valid new metrics and set norm_event=1 for that step; otherwise norm_event=0.
REQ-010 SHALL register pm, pv, decision, state_valid, best_state, best_metric and norm_event on the accepting edge, and pulse out_valid=1 the following cycle (latency 1).
REQ-011 SHALL choose best_state as the lowest index among valid states with the minimum post-normalisation metric; if no state is valid, best_state=0 and best_metric=0.
REQ-012 SHALL hold decision, state_valid, best_* and step_cnt between steps; out_valid and norm_event are zero when no step was accepted.
REQ-013 SHALL increment step_cnt per accepted step, saturating at 2^CW-1.
REQ-014 SHALL, on start=1, set pm all 0, pv = one-hot state 0 and step_cnt=0, with no out_valid next cycle; start takes priority over a simultaneous in_valid, which is dropped.

Reset
REQ-015 SHALL, with rst=1 at an edge, apply the REQ-014 initialisation and clear out_valid, decision, state_valid, best_state, best_metric and norm_event to 0.
REQ-016 SHALL give rst priority over start and in_valid, with no partial update when reset asserts mid-stream.

Verification (NSTATE=4, BMW=2, PMW=8)
REQ-017 SHALL cover first-step validity:
- stimulus: rst, then one step with all bm=1.
- response: out_valid=1 next cycle; state_valid=0101; decision=0000; best_state=0; best_metric=1; step_cnt=1.
REQ-018 SHALL cover tie-break:
- stimulus: after two steps with all bm=0, a step where both predecessors of state 1 are valid with equal candidates.
- response: decision[1]=0.
REQ-019 SHALL cover normalisation:
- stimulus: repeated steps with all bm=3.
- response: on the first step where every valid metric is >=128, norm_event=1 and each metric is reduced by 128.
REQ-020 SHALL cover start with in_valid:
- stimulus: start=1 and in_valid=1 together mid-stream.
- response: no out_valid next cycle; following step gives state_valid=0101; step_cnt=1.
REQ-021 SHALL cover mid-stream reset:
- stimulus: rst pulsed between two accepted steps.
- response: all outputs 0 the cycle after reset; the pending out_valid is suppressed.
REQ-022 SHALL cover counter saturation:
- stimulus: CW=4, 20 consecutive steps.
- response: step_cnt=15 and holds.
